// File: rtl/vga_frame_scanner.sv
// Programmable VGA timing generator with multiplier-free frame-buffer addressing,
// read-latency alignment and a writable class-code palette. Optional macro
// VGA_SCANNER_PATTERN_EN adds a test_mode input that substitutes colour bars.
module vga_frame_scanner #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int RD_LAT   = 2,
  parameter int BIN_W    = 3,
  parameter int ADDR_W   = 19
) (
  input  logic              video_clk,
  input  logic              reset_n,
  input  logic [BIN_W-1:0]  bin_data,
  output logic [ADDR_W-1:0] memory_addr,
  output logic              mem_rd_en,
  input  logic              pal_we,
  input  logic [BIN_W-1:0]  pal_idx,
  input  logic [11:0]       pal_rgb,
`ifdef VGA_SCANNER_PATTERN_EN
  input  logic              test_mode,
`endif
  output logic              hsync,
  output logic              vsync,
  output logic [11:0]       video_out,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int PAL_N   = 1 << BIN_W;

  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_LO_C  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_HI_C  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_LO_C  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_HI_C  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic          POL      = 1'(SYNC_POL);

  typedef struct packed {
    logic          act;
    logic          hs;
    logic          vs;
    logic          first;
`ifdef VGA_SCANNER_PATTERN_EN
    logic [HW-1:0] hc;
`endif
  } stage_t;

  function automatic logic [11:0] pal_default(input int i);
    case (i)
      0:       return 12'h000;
      1:       return 12'hF00;
      2:       return 12'h0F0;
      3:       return 12'h00F;
      4:       return 12'hF0F;
      default: return 12'hFFF;
    endcase
  endfunction

  logic [HW-1:0]     hcount_q, hcount_d;
  logic [VW-1:0]     vcount_q, vcount_d;
  logic [ADDR_W-1:0] idx_q, idx_d, last_q, last_d;
  logic              rd_en_q, rd_en_d;
  logic              h_last, frame_wrap, active0, act_next;
  stage_t            s0, tail;
  stage_t [RD_LAT-1:0] pipe_q;
  logic [PAL_N-1:0][11:0] pal_q;
  logic [BIN_W-1:0]  code;
  logic [11:0]       rgb_d, rgb_q;
  logic              hsync_d, hsync_q, vsync_d, vsync_q, fs_d, fs_q;
`ifdef VGA_SCANNER_PATTERN_EN
  logic              tm_q, tm_d;
`endif

  // Raster counters and stage-0 decode
  always_comb begin
    h_last     = (hcount_q == H_LAST_C);
    frame_wrap = h_last && (vcount_q == V_LAST_C);
    hcount_d   = h_last ? '0 : hcount_q + 1'b1;
    vcount_d   = vcount_q;
    if (h_last) vcount_d = (vcount_q == V_LAST_C) ? '0 : vcount_q + 1'b1;
    active0    = (hcount_q < H_ACT_C) && (vcount_q < V_ACT_C);
    act_next   = (hcount_d < H_ACT_C) && (vcount_d < V_ACT_C);
    s0         = '0;
    s0.act     = active0;
    s0.hs      = (hcount_q >= HS_LO_C) && (hcount_q <= HS_HI_C);
    s0.vs      = (vcount_q >= VS_LO_C) && (vcount_q <= VS_HI_C);
    s0.first   = (hcount_q == '0) && (vcount_q == '0);
`ifdef VGA_SCANNER_PATTERN_EN
    s0.hc      = hcount_q;
    tm_d       = frame_wrap ? test_mode : tm_q;
    rd_en_d    = act_next && !tm_d;
`else
    rd_en_d    = act_next;
`endif
  end

  // Running pixel index replaces v*H_ACTIVE+h; last_q holds it through blanking
  always_comb begin
    idx_d  = idx_q;
    last_d = last_q;
    if (active0) begin
      idx_d  = idx_q + ADDR_W'(1);
      last_d = idx_q;
    end
    if (frame_wrap) idx_d = '0;
  end

  assign memory_addr = active0 ? idx_q : last_q;
  assign mem_rd_en   = rd_en_q;

  always_ff @(posedge video_clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q <= '0;
      vcount_q <= '0;
      idx_q    <= '0;
      last_q   <= '0;
      rd_en_q  <= 1'b0;
`ifdef VGA_SCANNER_PATTERN_EN
      tm_q     <= 1'b0;
`endif
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      rd_en_q  <= rd_en_d;
`ifdef VGA_SCANNER_PATTERN_EN
      tm_q     <= tm_d;
`endif
    end
  end

  // Delay the decode by the memory latency so it meets the returned bin_data
  always_ff @(posedge video_clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= s0;
      for (int k = 1; k < RD_LAT; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign tail = pipe_q[RD_LAT-1];

  always_comb begin
    code = bin_data;
`ifdef VGA_SCANNER_PATTERN_EN
    if (tm_q) code = BIN_W'(tail.hc >> 6);
`endif
    rgb_d   = tail.act ? pal_q[code] : 12'h000;
    hsync_d = tail.hs ? POL : ~POL;
    vsync_d = tail.vs ? POL : ~POL;
    fs_d    = tail.first && tail.act;
  end

  // Same-cycle palette write is seen by the next read, not this one
  always_ff @(posedge video_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PAL_N; i++) pal_q[i] <= pal_default(i);
      rgb_q   <= '0;
      hsync_q <= ~POL;
      vsync_q <= ~POL;
      fs_q    <= 1'b0;
    end else begin
      if (pal_we) pal_q[pal_idx] <= pal_rgb;
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      fs_q    <= fs_d;
    end
  end

  assign video_out   = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Randomised bench: frame-buffer and palette writes against a positional
// reference model; a second instance checks positive-polarity sync counts.
module tb_vga_frame_scanner;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
  localparam int LAT = 2, BW = 3, AW = 7;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int L = LAT + 1;
  localparam int NPIX = HA * VA;
  localparam int FR = HT * VT;

  localparam int HA2 = 10, HF2 = 2, HS2 = 4, HB2 = 4;
  localparam int VA2 = 4,  VF2 = 1, VS2 = 2, VB2 = 2;
  localparam int HT2 = HA2 + HF2 + HS2 + HB2;
  localparam int VT2 = VA2 + VF2 + VS2 + VB2;
  localparam int FR2 = HT2 * VT2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [BW-1:0] bin_data, pal_idx, bin2;
  logic          pal_we;
  logic [11:0]   pal_rgb;
  logic [AW-1:0] memory_addr;
  logic          mem_rd_en, hsync, vsync, frame_start;
  logic [11:0]   video_out;
  logic [5:0]    addr2;
  logic          rd2, hs2, vs2, fs2;
  logic [11:0]   vid2;
`ifdef VGA_SCANNER_PATTERN_EN
  logic          test_mode = 1'b0;
`endif

  vga_frame_scanner #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(0), .RD_LAT(LAT), .BIN_W(BW), .ADDR_W(AW)
  ) u_dut (
    .video_clk(clk), .reset_n(rst_n), .bin_data(bin_data),
    .memory_addr(memory_addr), .mem_rd_en(mem_rd_en),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb),
`ifdef VGA_SCANNER_PATTERN_EN
    .test_mode(test_mode),
`endif
    .hsync(hsync), .vsync(vsync), .video_out(video_out), .frame_start(frame_start)
  );

  vga_frame_scanner #(
    .H_ACTIVE(HA2), .H_FP(HF2), .H_SYNC(HS2), .H_BP(HB2),
    .V_ACTIVE(VA2), .V_FP(VF2), .V_SYNC(VS2), .V_BP(VB2),
    .SYNC_POL(1), .RD_LAT(1), .BIN_W(BW), .ADDR_W(6)
  ) u_pol (
    .video_clk(clk), .reset_n(rst_n), .bin_data(bin2),
    .memory_addr(addr2), .mem_rd_en(rd2),
    .pal_we(1'b0), .pal_idx('0), .pal_rgb(12'h000),
`ifdef VGA_SCANNER_PATTERN_EN
    .test_mode(1'b0),
`endif
    .hsync(hs2), .vsync(vs2), .video_out(vid2), .frame_start(fs2)
  );

  typedef struct { int s; logic [BW-1:0] idx; logic [11:0] rgb; } wr_t;
  typedef struct { logic [AW-1:0] a; bit act; } rd_t;

  int            checks = 0, errors = 0, t = 0;
  logic [BW-1:0] mem [NPIX];
  logic [11:0]   pal_m [8];
  wr_t           wq[$];
  rd_t           rq[$];
  int            n_hs2, n_vs2, n_fs2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  function automatic bit act_at(input int p);
    return ((p % HT) < HA) && (((p / HT) % VT) < VA);
  endfunction

  // Address the scanner should be presenting at raster position p
  function automatic int exp_addr(input int p);
    int h, v;
    h = p % HT;
    v = (p / HT) % VT;
    if (v >= VA) return NPIX - 1;
    if (h >= HA) return v * HA + HA - 1;
    return v * HA + h;
  endfunction

  task automatic model_reset();
    t = 0;
    pal_m = '{12'h000, 12'hF00, 12'h0F0, 12'h00F, 12'hF0F, 12'hFFF, 12'hFFF, 12'hFFF};
    wq.delete();
    rq.delete();
  endtask

  task automatic chk_reset_vals();
    chk("rst_video", 32'(video_out), 32'h0);
    chk("rst_hsync", 32'(hsync), 32'h1);
    chk("rst_vsync", 32'(vsync), 32'h1);
    chk("rst_fs",    32'(frame_start), 32'h0);
    chk("rst_addr",  32'(memory_addr), 32'h0);
    chk("rst_rden",  32'(mem_rd_en), 32'h0);
    chk("rst_hs2",   32'(hs2), 32'h0);
  endtask

  // One raster cycle: compare outputs, then drive the memory reply and palette
  task automatic step();
    int p, h, v;
    rd_t r;
    wr_t w;
    p = t - L;
    while (wq.size() > 0 && wq[0].s <= t - 2) begin
      w = wq.pop_front();
      pal_m[w.idx] = w.rgb;
    end
    if (p < 0) begin
      chk("video", 32'(video_out), 32'h0);
      chk("hsync", 32'(hsync), 32'h1);
      chk("vsync", 32'(vsync), 32'h1);
      chk("fstart", 32'(frame_start), 32'h0);
    end else begin
      h = p % HT;
      v = (p / HT) % VT;
      chk("video", 32'(video_out), (h < HA && v < VA) ? 32'(pal_m[mem[v * HA + h]]) : 32'h0);
      chk("hsync", 32'(hsync), (h >= HA + HF && h < HA + HF + HS) ? 32'h0 : 32'h1);
      chk("vsync", 32'(vsync), (v >= VA + VF && v < VA + VF + VS) ? 32'h0 : 32'h1);
      chk("fstart", 32'(frame_start), (h == 0 && v == 0) ? 32'h1 : 32'h0);
    end
    chk("addr", 32'(memory_addr), 32'(exp_addr(t)));
    chk("rden", 32'(mem_rd_en), (t > 0 && act_at(t)) ? 32'h1 : 32'h0);

    rq.push_back('{memory_addr, act_at(t)});
    bin_data = BW'($urandom);
    if (rq.size() > LAT) begin
      r = rq.pop_front();
      if (r.act && int'(r.a) < NPIX) bin_data = mem[r.a];
    end
    bin2 = BW'($urandom);
    pal_we = ($urandom_range(0, 15) == 0);
    pal_idx = BW'($urandom);
    pal_rgb = 12'($urandom);
    if (t == 2 * HT + 5) begin
      pal_we = 1'b1;
      pal_idx = 3'd1;
      pal_rgb = 12'h0AB;
    end
    if (pal_we) wq.push_back('{t, pal_idx, pal_rgb});

    if (t < 2 * FR2) begin
      n_hs2 += int'(hs2);
      n_vs2 += int'(vs2);
      n_fs2 += int'(fs2);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      step();
      @(negedge clk);
      t++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bin_data = '0;
    bin2 = '0;
    pal_we = 1'b0;
    pal_idx = '0;
    pal_rgb = '0;
    for (int i = 0; i < NPIX; i++) mem[i] = (i < HA) ? BW'(i % 8) : BW'($urandom);
    repeat (3) @(negedge clk);
    chk_reset_vals();
    model_reset();
    n_hs2 = 0; n_vs2 = 0; n_fs2 = 0;
    rst_n = 1'b1;
    run(3 * FR);

    run(8);
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    pal_we = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    n_hs2 = 0; n_vs2 = 0; n_fs2 = 0;
    rst_n = 1'b1;
    run(2 * FR);

    chk("pol_hsync_cnt", 32'(n_hs2), 32'(2 * VT2 * HS2));
    chk("pol_vsync_cnt", 32'(n_vs2), 32'(2 * VS2 * HT2));
    chk("pol_fstart_cnt", 32'(n_fs2), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
